// File: rtl/dmem_debug_scheduler_if.sv
// Host-debug command/response and memory debug-port bundle for dmem_debug_scheduler.
// master = host/memory side, slave = scheduler.
interface dmem_debug_scheduler_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_mem_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [41:0]       rsp_data;

    logic              write_mem_req;
    logic              target_mem_type;
    logic [ADDR_W-1:0] target_addr;
    logic              rw_flag;
    logic [31:0]       uart_rx_data_out;
    logic              mem_tx_ready;
    logic [41:0]       mem_tx_data;

    modport master (
        output cmd_valid, cmd_write, cmd_mem_type, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  write_mem_req, target_mem_type, target_addr, rw_flag, uart_rx_data_out,
        output mem_tx_ready, mem_tx_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_mem_type, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output write_mem_req, target_mem_type, target_addr, rw_flag, uart_rx_data_out,
        input  mem_tx_ready, mem_tx_data
    );
endinterface

// File: rtl/dmem_debug_scheduler.sv
// Halts the pipeline, drains in-flight memory ops, issues one debug memory access per
// host command and returns exactly one response before restoring the CPU run state.
module dmem_debug_scheduler #(
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run_req,
    output logic                   cpu_enable,
    input  logic                   cpu_mem_active,
    output logic                   busy,
    dmem_debug_scheduler_if.slave  bus
);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StDrain, StIssue, StWait, StResp} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_cpu_enable;
    logic                r_target_mem_type;
    logic [ADDR_W-1:0]   r_target_addr;
    logic                r_rw_flag;
    logic [31:0]         r_wdata;
    logic [41:0]         r_rsp_data;
    logic                w_drain_done;
    logic                w_timeout;
    logic [41:0]         w_err_word;

    assign w_drain_done = (r_drain_cnt == '0) && !cpu_mem_active;
    assign w_timeout    = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign w_err_word   = {1'b1, 41'({r_target_addr, 32'h0})};

    assign bus.cmd_ready        = (r_state == StIdle) && rst_n;
    assign bus.rsp_valid        = (r_state == StResp);
    assign bus.rsp_data         = r_rsp_data;
    assign bus.write_mem_req    = (r_state == StIssue);
    assign bus.target_mem_type  = r_target_mem_type;
    assign bus.target_addr      = r_target_addr;
    assign bus.rw_flag          = r_rw_flag;
    assign bus.uart_rx_data_out = r_wdata;
    assign cpu_enable           = r_cpu_enable;
    assign busy                 = (r_state != StIdle);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (bus.cmd_valid) w_state_d = StDrain;
            StDrain: begin
                if (w_drain_done)   w_state_d = StIssue;
                else if (w_timeout) w_state_d = StResp;
            end
            StIssue: w_state_d = r_rw_flag ? StResp : StWait;
            StWait:  if (bus.mem_tx_ready || w_timeout) w_state_d = StResp;
            StResp:  if (bus.rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= StIdle;
            r_drain_cnt       <= '0;
            r_timer           <= '0;
            r_cpu_enable      <= 1'b0;
            r_target_mem_type <= 1'b0;
            r_target_addr     <= '0;
            r_rw_flag         <= 1'b0;
            r_wdata           <= '0;
            r_rsp_data        <= '0;
        end else begin
            r_state <= w_state_d;
            // Timer measures time spent in the current state and saturates at the limit.
            if (w_state_d != r_state) r_timer <= '0;
            else if (!w_timeout)      r_timer <= r_timer + TIMER_W'(1);

            if (r_state == StIdle && bus.cmd_valid) begin
                r_target_mem_type <= bus.cmd_mem_type;
                r_target_addr     <= bus.cmd_addr;
                r_rw_flag         <= bus.cmd_write;
                r_wdata           <= bus.cmd_wdata;
                r_drain_cnt       <= DRAIN_W'(DRAIN_CYCLES - 1);
            end else if (r_drain_cnt != '0) begin
                r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
            end

            // Run state follows run_req only while idle, including the returning edge.
            r_cpu_enable <= (w_state_d == StIdle) ? run_req : 1'b0;

            case (r_state)
                StDrain: if (!w_drain_done && w_timeout) r_rsp_data <= w_err_word;
                StIssue: if (r_rw_flag) r_rsp_data <= {1'b0, 41'({r_target_addr, 32'h0})};
                StWait: begin
                    if (bus.mem_tx_ready) r_rsp_data <= bus.mem_tx_data & {1'b0, {41{1'b1}}};
                    else if (w_timeout)   r_rsp_data <= w_err_word;
                end
                default: ;
            endcase
        end
    end
endmodule
